pending_prio_encoder: RTL and testbench

//  Parametrised N-to-log2(N) priority encoder with request memory and output handshake.

---
 rtl/enc_pkg.sv | 19 +
 rtl/prio_enc.sv | 41 ++++
 rtl/pending_prio_encoder.sv | 98 +++++++++
 tb/tb_pending_prio_encoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared sizing, reset constant and one-hot helpers for pending_prio_encoder
package enc_pkg;

    localparam int unsigned MAX_N = 1024;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin pointer starts at the top so the first search begins at index 0.
    function automatic int unsigned rr_ptr_reset(input int unsigned n);
        return n - 1;
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - combinational search of a request vector from a start index (RR_PRIORITY_EN selects round-robin)
module prio_enc
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

`ifdef RR_PRIORITY_EN
    logic [N-1:0] rot;

    // Rotate so start_i lands at bit 0; the lowest set bit of rot is the winner.
    always_comb begin
        rot   = N'({vec_i, vec_i} >> start_i);
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx_o = W'((32'(start_i) + 32'(k)) % 32'(N));
            end
        end
    end
`else
    // Downward search from start_i: the highest set index not above start_i wins.
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (W'(k) <= start_i && vec_i[k]) begin
                idx_o = W'(k);
            end
        end
    end
`endif

    assign any_o = |vec_i;

endmodule

// File: rtl/pending_prio_encoder.sv
// rtl/pending_prio_encoder.sv - pending-request priority encoder with handshake; RR_PRIORITY_EN enables round-robin
module pending_prio_encoder
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [N-1:0] D,
    output logic [W-1:0] Q,
    output logic         VALID,
    input  logic         READY,
    output logic [N-1:0] PEND
);

    logic [N-1:0] p_q, p_d;
    logic [N-1:0] take;
    logic [W-1:0] q_q, q_d;
    logic         valid_q, valid_d;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         sel_any;
    logic         ld;

`ifdef RR_PRIORITY_EN
    logic [W-1:0] ptr_q, ptr_d;

    assign start = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
`else
    assign start = W'(N - 1);
`endif

    prio_enc #(
        .N(N),
        .W(W)
    ) u_prio_enc (
        .vec_i  (p_q),
        .start_i(start),
        .idx_o  (sel_idx),
        .any_o  (sel_any)
    );

    assign ld = EN & (~valid_q | READY);

    always_comb begin
        p_d     = p_q;
        q_d     = q_q;
        valid_d = valid_q;
        take    = '0;
`ifdef RR_PRIORITY_EN
        ptr_d   = ptr_q;
`endif
        if (ld) begin
            if (sel_any) begin
                q_d     = sel_idx;
                valid_d = 1'b1;
                take    = N'(onehot(32'(sel_idx)));
`ifdef RR_PRIORITY_EN
                ptr_d   = sel_idx;
`endif
            end else begin
                valid_d = 1'b0;
            end
        end else if (!EN && valid_q && READY) begin
            // Disabled: let the outstanding transfer finish but start nothing new.
            valid_d = 1'b0;
        end
        // OR-ing D last makes a fresh request win over the bit being served.
        if (EN) begin
            p_d = (p_q & ~take) | D;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_q     <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
`ifdef RR_PRIORITY_EN
            ptr_q   <= W'(rr_ptr_reset(N));
`endif
        end else begin
            p_q     <= p_d;
            q_q     <= q_d;
            valid_q <= valid_d;
`ifdef RR_PRIORITY_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign PEND  = p_q;

endmodule

// File: tb/tb_pending_prio_encoder.sv
// tb/tb_pending_prio_encoder.sv - scoreboard bench for pending_prio_encoder against a set-based reference model
module tb_pending_prio_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         CLK;
    logic         RST;
    logic         EN;
    logic [N-1:0] D;
    logic [W-1:0] Q;
    logic         VALID;
    logic         READY;
    logic [N-1:0] PEND;

    pending_prio_encoder #(.N(N)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .D    (D),
        .Q    (Q),
        .VALID(VALID),
        .READY(READY),
        .PEND (PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a set of pending line numbers plus a one-entry output slot.
    bit m_pend[N];
    bit m_valid;
    int m_q;
    int m_ptr;
    int exp_q[$];

    int cur_pend;
    int cur_valid;
    int cur_q;

    int n_cmp;
    int n_fail;
    event sample_ev;

    function automatic int pend_as_int();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v += (1 << i);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_valid = 0;
        m_q     = 0;
        m_ptr   = N - 1;
        exp_q.delete();
    endfunction

    function automatic int pick();
        int winner = -1;
`ifdef RR_PRIORITY_EN
        for (int k = 1; k <= N; k++) begin
            int i = (m_ptr + k) % N;
            if (winner < 0 && m_pend[i]) winner = i;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (winner < 0 && m_pend[i]) winner = i;
        end
`endif
        return winner;
    endfunction

    // Advances the model across the coming rising edge.
    function automatic void model_step(input bit en, input bit rdy, input logic [N-1:0] d);
        int sel = -1;
        if (en && (!m_valid || rdy)) begin
            sel = pick();
            if (sel >= 0) begin
                m_valid = 1;
                m_q     = sel;
                m_ptr   = sel;
                exp_q.push_back(sel);
            end else begin
                m_valid = 0;
            end
        end else if (!en && m_valid && rdy) begin
            m_valid = 0;
        end
        if (en) begin
            if (sel >= 0) m_pend[sel] = 0;
            for (int i = 0; i < N; i++) if (d[i]) m_pend[i] = 1;
        end
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit rdy, input logic [N-1:0] d);
        @(negedge CLK);
        RST   = rst;
        EN    = en;
        READY = rdy;
        D     = d;
        if (rst) begin
            model_reset();
            cur_pend  = 0;
            cur_valid = 0;
            cur_q     = 0;
        end else begin
            cur_pend  = pend_as_int();
            cur_valid = int'(m_valid);
            cur_q     = m_q;
            model_step(en, rdy, d);
        end
        ->sample_ev;
    endtask

    // Monitor: checks state between edges and pops the scoreboard on every accepted transfer.
    initial begin
        forever begin
            @(sample_ev);
            #3;
            check("pend", int'(PEND), cur_pend);
            check("valid", int'(VALID), cur_valid);
            check("q", int'(Q), cur_q);
            if (VALID && READY && !RST) begin
                if (exp_q.size() == 0) begin
                    check("accept_without_issue", 1, 0);
                end else begin
                    check("accepted_index", int'(Q), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        RST    = 1'b1;
        EN     = 1'b0;
        READY  = 1'b0;
        D      = '0;
        model_reset();

        // Reset with everything requesting, then a clean release.
        repeat (3) cyc(1, 1, 1, 8'hFF);
        cyc(0, 1, 1, 8'h00);

        // Fixed order 7,2,0 from a single burst.
        cyc(0, 1, 1, 8'b1000_0101);
        repeat (5) cyc(0, 1, 1, 8'h00);

        // Backpressure holds Q while P accumulates.
        cyc(0, 1, 0, 8'h10);
        repeat (2) cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h80);
        cyc(0, 1, 0, 8'h00);
        repeat (3) cyc(0, 1, 1, 8'h00);

        // Disabled: D ignored; an outstanding transfer still completes.
        repeat (3) cyc(0, 0, 1, 8'h01);
        cyc(0, 1, 0, 8'h04);
        cyc(0, 1, 0, 8'h00);
        repeat (3) cyc(0, 0, 1, 8'h00);
        repeat (2) cyc(0, 1, 1, 8'h00);

        // Re-request of the index currently in Q.
        cyc(0, 1, 0, 8'h10);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h10);
        cyc(0, 1, 0, 8'h00);
        repeat (4) cyc(0, 1, 1, 8'h00);

        // All lines held high.
        repeat (12) cyc(0, 1, 1, 8'hFF);
        repeat (10) cyc(0, 1, 1, 8'h00);

        // Random traffic, including occasional resets mid-transfer.
        for (int i = 0; i < 600; i++) begin
            bit            r_rst;
            bit            r_en;
            bit            r_rdy;
            logic [N-1:0]  r_d;
            r_rst = ($urandom_range(0, 59) == 0);
            r_en  = ($urandom_range(0, 7) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_d   = N'($urandom) & N'($urandom);
            cyc(r_rst, r_en, r_rdy, r_d);
        end

        repeat (12) cyc(0, 1, 1, 8'h00);
        #4;
        check("drained_valid", int'(VALID), 0);
        check("drained_pend", int'(PEND), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
